// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo core.
//   - Default configuration constants (depth, result width, register index width).
//   - rob_entry_t: reorder-buffer entry layout at the default widths.
//   - tag_width(): derives the tag width from the number of entries.
package tomasulo_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  // A single-entry buffer would still need a 1-bit tag port.
  function automatic int tag_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [DEF_REG_W-1:0]  dest;
    logic [DEF_DATA_W-1:0] value;
  } rob_entry_t;

endpackage

// File: rtl/rob_lookup_port.sv
// Combinational operand read port of the reorder buffer with CDB bypass.
// Ports:
//   tag          : entry being looked up
//   entry_busy/entry_done/entry_value : stored state of that entry
//   cdb_valid/cdb_tag/cdb_data        : current CDB broadcast
//   ready/data   : operand availability and value (zero when the entry is free)
module rob_lookup_port #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
) (
  input  logic [TAG_W-1:0]  tag,
  input  logic              entry_busy,
  input  logic              entry_done,
  input  logic [DATA_W-1:0] entry_value,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              ready,
  output logic [DATA_W-1:0] data
);

  logic bypass;

  always_comb begin
    bypass = cdb_valid && (cdb_tag == tag) && entry_busy;
    ready  = 1'b0;
    data   = '0;
    // A result on the CDB this cycle is forwarded before it is written,
    // so the reservation station does not miss it by one cycle.
    if (bypass) begin
      ready = 1'b1;
      data  = cdb_data;
    end else if (entry_busy) begin
      ready = entry_done;
      data  = entry_value;
    end
  end

endmodule

// File: rtl/reorder_queue.sv
// Circular reorder buffer: allocates one entry per issued instruction,
// captures CDB results, forwards operands with bypass and retires strictly
// in program order to the register file.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   alloc_valid/alloc_dest      : issue request and its destination register
//   alloc_ready/alloc_tag       : entry available / tag granted (tail)
//   cdb_valid/cdb_tag/cdb_data  : result broadcast
//   lookup_tag_{j,k}            : operand tags, answered by
//   lookup_ready_{j,k}/lookup_data_{j,k}
//   commit_retire/wen/idx/data/tag : registered retire pulse and payload
//   flush                       : synchronous discard of all entries
//   count/full/empty            : occupancy
//
// Allocate handshake: an entry is taken on a rising edge where
// alloc_valid && alloc_ready. alloc_ready depends only on registered state
// (never on alloc_valid), and alloc_tag is valid in the same cycle as the
// request. alloc_valid while !alloc_ready is dropped with no state change.
module reorder_queue import tomasulo_pkg::*; #(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int TAG_W  = tag_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  lookup_tag_j,
  input  logic [TAG_W-1:0]  lookup_tag_k,
  output logic              lookup_ready_j,
  output logic              lookup_ready_k,
  output logic [DATA_W-1:0] lookup_data_j,
  output logic [DATA_W-1:0] lookup_data_k,
  output logic              commit_retire,
  output logic              commit_wen,
  output logic [REG_W-1:0]  commit_idx,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  input  logic              flush,
  output logic [TAG_W:0]    count,
  output logic              full,
  output logic              empty
);

  // Same layout as rob_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } entry_t;

  entry_t            entries [DEPTH];
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count_q;

  logic alloc_fire;
  logic retire_fire;
  logic cdb_hit;

  // Occupancy flags come from the registered count, so a retire never
  // frees a slot for an allocation in the same cycle.
  assign full        = (count_q == (TAG_W+1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign alloc_ready = !full;
  assign alloc_tag   = tail;

  // Flush overrides every other update in its cycle.
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign retire_fire = entries[head].busy && entries[head].done && !flush;
  // The tail entry is not busy before the edge, so a CDB aimed at it is
  // dropped here without special casing.
  assign cdb_hit     = cdb_valid && entries[cdb_tag].busy &&
                       !entries[cdb_tag].done && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].busy <= 1'b0;
        entries[i].done <= 1'b0;
      end
    end else begin
      // cdb_hit requires !done and retire_fire requires done, and the tail
      // is never busy when an allocation happens, so these three updates
      // never touch the same entry.
      if (cdb_hit) begin
        entries[cdb_tag].done  <= 1'b1;
        entries[cdb_tag].value <= cdb_data;
      end
      if (retire_fire) begin
        entries[head].busy <= 1'b0;
        entries[head].done <= 1'b0;
      end
      if (alloc_fire) begin
        entries[tail].busy <= 1'b1;
        entries[tail].done <= 1'b0;
        entries[tail].dest <= alloc_dest;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (alloc_fire) begin
        tail <= tail + 1'b1;
      end
      if (retire_fire) begin
        head <= head + 1'b1;
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Commit payload holds its last value between pulses; only the pulse and
  // write enable drop back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_retire <= 1'b0;
      commit_wen    <= 1'b0;
      commit_idx    <= '0;
      commit_data   <= '0;
      commit_tag    <= '0;
    end else begin
      commit_retire <= retire_fire;
      commit_wen    <= retire_fire && (entries[head].dest != '0);
      if (retire_fire) begin
        commit_idx  <= entries[head].dest;
        commit_data <= entries[head].value;
        commit_tag  <= head;
      end
    end
  end

  rob_lookup_port #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_lookup_j (
    .tag         (lookup_tag_j),
    .entry_busy  (entries[lookup_tag_j].busy),
    .entry_done  (entries[lookup_tag_j].done),
    .entry_value (entries[lookup_tag_j].value),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .ready       (lookup_ready_j),
    .data        (lookup_data_j)
  );

  rob_lookup_port #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_lookup_k (
    .tag         (lookup_tag_k),
    .entry_busy  (entries[lookup_tag_k].busy),
    .entry_done  (entries[lookup_tag_k].done),
    .entry_value (entries[lookup_tag_k].value),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .ready       (lookup_ready_k),
    .data        (lookup_data_k)
  );

endmodule

// File: tb/tb_reorder_queue.sv
// Bench for reorder_queue (default DEPTH=8, DATA_W=32, REG_W=5).
// Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_reorder_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int TAG_W  = 3;
  localparam int REC_W  = 1 + TAG_W + REG_W + DATA_W;

  typedef struct packed {
    logic              wen;
    logic [TAG_W-1:0]  tag;
    logic [REG_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } commit_rec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  lookup_tag_j, lookup_tag_k;
  logic              lookup_ready_j, lookup_ready_k;
  logic [DATA_W-1:0] lookup_data_j, lookup_data_k;
  logic              commit_retire, commit_wen;
  logic [REG_W-1:0]  commit_idx;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;
  logic              flush;
  logic [TAG_W:0]    count;
  logic              full, empty;

  reorder_queue dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .lookup_tag_j(lookup_tag_j), .lookup_tag_k(lookup_tag_k),
    .lookup_ready_j(lookup_ready_j), .lookup_ready_k(lookup_ready_k),
    .lookup_data_j(lookup_data_j), .lookup_data_k(lookup_data_k),
    .commit_retire(commit_retire), .commit_wen(commit_wen),
    .commit_idx(commit_idx), .commit_data(commit_data), .commit_tag(commit_tag),
    .flush(flush), .count(count), .full(full), .empty(empty)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Program order is a queue of tags; the entry table only records what the
  // instruction owning each tag has produced so far.
  bit              m_busy [DEPTH];
  bit              m_done [DEPTH];
  bit [REG_W-1:0]  m_dest [DEPTH];
  bit [DATA_W-1:0] m_val  [DEPTH];
  int              rob_q[$];
  int              m_tail = 0;
  logic [REC_W-1:0] exp_q[$];

  int  mh;
  bit  m_ret;
  bit  m_can_alloc;
  commit_rec_t m_rec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_busy[i] = 0; m_done[i] = 0; m_dest[i] = '0; m_val[i] = '0;
      end
      rob_q.delete();
      exp_q.delete();
      m_tail = 0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_busy[i] = 0; m_done[i] = 0;
      end
      rob_q.delete();
      m_tail = 0;
    end else begin
      m_can_alloc = (rob_q.size() < DEPTH);
      mh    = (rob_q.size() > 0) ? rob_q[0] : 0;
      m_ret = (rob_q.size() > 0) && m_done[mh];
      if (cdb_valid && m_busy[cdb_tag] && !m_done[cdb_tag]) begin
        m_done[cdb_tag] = 1;
        m_val[cdb_tag]  = cdb_data;
      end
      if (m_ret) begin
        m_rec.wen  = (m_dest[mh] != 0);
        m_rec.tag  = TAG_W'(mh);
        m_rec.idx  = m_dest[mh];
        m_rec.data = m_val[mh];
        exp_q.push_back(REC_W'(m_rec));
        m_busy[mh] = 0;
        m_done[mh] = 0;
        void'(rob_q.pop_front());
      end
      if (alloc_valid && m_can_alloc) begin
        m_busy[m_tail] = 1;
        m_done[m_tail] = 0;
        m_dest[m_tail] = alloc_dest;
        rob_q.push_back(m_tail);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  end

  task automatic chk_lookup(input string nm, input logic [TAG_W-1:0] t,
                            input logic rdy, input logic [DATA_W-1:0] d);
    bit byp;
    bit er;
    byp = cdb_valid && (cdb_tag == t) && m_busy[t];
    er  = m_busy[t] && (m_done[t] || byp);
    check({nm, "_ready"}, 64'(rdy), 64'(er));
    if (!m_busy[t])
      check({nm, "_data_free"}, 64'(d), 64'd0);
    else if (er)
      check({nm, "_data"}, 64'(d), 64'(byp ? cdb_data : m_val[t]));
  endtask

  // ---------------- compare process (scoreboard) ----------------
  commit_rec_t c_rec;
  always @(negedge clk) begin
    #2;
    check("count", 64'(count), 64'(rob_q.size()));
    check("full",  64'(full),  64'(rob_q.size() == DEPTH));
    check("empty", 64'(empty), 64'(rob_q.size() == 0));
    check("alloc_ready", 64'(alloc_ready), 64'(rob_q.size() < DEPTH));
    check("alloc_tag", 64'(alloc_tag), 64'(m_tail));
    chk_lookup("lookup_j", lookup_tag_j, lookup_ready_j, lookup_data_j);
    chk_lookup("lookup_k", lookup_tag_k, lookup_ready_k, lookup_data_k);
    if (exp_q.size() > 0) begin
      c_rec = commit_rec_t'(exp_q.pop_front());
      check("commit_retire", 64'(commit_retire), 64'd1);
      check("commit_wen",  64'(commit_wen),  64'(c_rec.wen));
      check("commit_tag",  64'(commit_tag),  64'(c_rec.tag));
      check("commit_idx",  64'(commit_idx),  64'(c_rec.idx));
      check("commit_data", 64'(commit_data), 64'(c_rec.data));
      check("retire_backlog", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end else begin
      check("commit_retire_idle", 64'(commit_retire), 64'd0);
      check("commit_wen_idle", 64'(commit_wen), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    alloc_valid = 0; alloc_dest = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    lookup_tag_j = '0; lookup_tag_k = '0;
    flush = 0;
  endtask

  task automatic drive_alloc(input logic v, input int d);
    alloc_valid = v;
    alloc_dest  = REG_W'(d);
  endtask

  task automatic drive_cdb(input logic v, input int t, input logic [DATA_W-1:0] d);
    cdb_valid = v;
    cdb_tag   = TAG_W'(t);
    cdb_data  = d;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int seen;
  int got_cyc [3];
  logic [DATA_W-1:0] got_data [3];
  logic [TAG_W-1:0]  got_tag  [3];
  logic [REG_W-1:0]  got_idx  [3];
  logic [DATA_W-1:0] wrap_data;
  int t;

  initial begin
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    check("rst_alloc_tag", 64'(alloc_tag), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_commit_retire", 64'(commit_retire), 64'd0);
    check("rst_commit_wen", 64'(commit_wen), 64'd0);
    check("rst_commit_idx", 64'(commit_idx), 64'd0);
    check("rst_commit_data", 64'(commit_data), 64'd0);
    check("rst_commit_tag", 64'(commit_tag), 64'd0);
    check("rst_lookup_ready", 64'(lookup_ready_j), 64'd0);
    check("rst_lookup_data", 64'(lookup_data_j), 64'd0);

    // Fill: tags 0..7, then a 9th request while full.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_alloc(1, i + 1);
      #1 check("fill_tag", 64'(alloc_tag), 64'(i));
    end
    @(negedge clk);
    drive_alloc(1, 9);
    #1;
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(alloc_ready), 64'd0);
    check("fill_count", 64'(count), 64'd8);
    @(negedge clk);
    drive_alloc(0, 0);
    #1;
    check("ninth_ignored_count", 64'(count), 64'd8);
    check("ninth_ignored_tail", 64'(alloc_tag), 64'd0);

    // Out-of-order completion, in-order retirement.
    @(negedge clk); drive_cdb(1, 2, 32'hA);
    @(negedge clk); drive_cdb(1, 1, 32'hB);
    @(negedge clk); drive_cdb(1, 0, 32'hC);
    @(negedge clk); drive_cdb(0, 0, '0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (commit_retire === 1'b1 && seen < 3) begin
        got_cyc[seen]  = c;
        got_data[seen] = commit_data;
        got_tag[seen]  = commit_tag;
        got_idx[seen]  = commit_idx;
        seen++;
      end
    end
    check("ooo_retire_count", 64'(seen), 64'd3);
    if (seen == 3) begin
      check("ooo_first_cycle", 64'(got_cyc[0]), 64'd0);
      check("ooo_back_to_back", 64'(got_cyc[2] - got_cyc[0]), 64'd2);
      check("ooo_tag0", 64'(got_tag[0]), 64'd0);
      check("ooo_tag1", 64'(got_tag[1]), 64'd1);
      check("ooo_tag2", 64'(got_tag[2]), 64'd2);
      check("ooo_data0", 64'(got_data[0]), 64'hC);
      check("ooo_data1", 64'(got_data[1]), 64'hB);
      check("ooo_data2", 64'(got_data[2]), 64'hA);
      check("ooo_idx0", 64'(got_idx[0]), 64'd1);
      check("ooo_idx2", 64'(got_idx[2]), 64'd3);
    end
    check("ooo_count_after", 64'(count), 64'd5);

    // Same-cycle CDB bypass on tag 3.
    @(negedge clk);
    drive_cdb(1, 3, 32'h55);
    lookup_tag_j = 3'd3;
    lookup_tag_k = 3'd4;
    #1;
    check("bypass_ready", 64'(lookup_ready_j), 64'd1);
    check("bypass_data", 64'(lookup_data_j), 64'h55);
    check("bypass_other_not_ready", 64'(lookup_ready_k), 64'd0);
    @(negedge clk);
    drive_cdb(0, 0, '0);
    #1;
    check("stored_ready", 64'(lookup_ready_j), 64'd1);
    check("stored_data", 64'(lookup_data_j), 64'h55);
    @(negedge clk);
    #1;
    check("tag3_retire", 64'(commit_retire), 64'd1);
    check("tag3_commit_tag", 64'(commit_tag), 64'd3);
    check("tag3_commit_data", 64'(commit_data), 64'h55);

    // Four busy (4..7), two done (5,6), then flush.
    @(negedge clk); drive_cdb(1, 5, 32'h66);
    @(negedge clk); drive_cdb(1, 6, 32'h67);
    @(negedge clk); drive_cdb(0, 0, '0);
    #1;
    check("preflush_count", 64'(count), 64'd4);
    check("preflush_no_retire", 64'(commit_retire), 64'd0);
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    #1;
    check("flush_count", 64'(count), 64'd0);
    check("flush_empty", 64'(empty), 64'd1);
    check("flush_no_retire", 64'(commit_retire), 64'd0);
    @(negedge clk);
    drive_alloc(1, 10);
    #1 check("postflush_tag", 64'(alloc_tag), 64'd0);
    @(negedge clk);
    drive_alloc(0, 0);
    drive_cdb(1, 5, 32'h77);
    lookup_tag_j = 3'd5;
    #1;
    check("stale_cdb_lookup_ready", 64'(lookup_ready_j), 64'd0);
    check("stale_cdb_lookup_data", 64'(lookup_data_j), 64'd0);
    @(negedge clk);
    drive_cdb(0, 0, '0);
    #1;
    check("stale_cdb_count", 64'(count), 64'd1);
    check("stale_cdb_no_retire", 64'(commit_retire), 64'd0);
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;

    // Wrap: one entry in flight at a time, 12 times; dest 0 every 4th.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive_alloc(1, i % 4);
      #1;
      check("wrap_tag", 64'(alloc_tag), 64'(i % 8));
      check("wrap_count0", 64'(count), 64'd0);
      @(negedge clk);
      drive_alloc(0, 0);
      wrap_data = $urandom();
      drive_cdb(1, i % 8, wrap_data);
      #1 check("wrap_count1", 64'(count), 64'd1);
      @(negedge clk);
      drive_cdb(0, 0, '0);
      #1;
      check("wrap_count2", 64'(count), 64'd1);
      check("wrap_wait", 64'(commit_retire), 64'd0);
      @(negedge clk);
      #1;
      check("wrap_retire", 64'(commit_retire), 64'd1);
      check("wrap_commit_tag", 64'(commit_tag), 64'(i % 8));
      check("wrap_commit_wen", 64'(commit_wen), 64'((i % 4) != 0));
      check("wrap_commit_data", 64'(commit_data), 64'(wrap_data));
    end
    check("wrap_empty", 64'(empty), 64'd1);

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      alloc_valid = ($urandom_range(0, 99) < 60);
      alloc_dest  = REG_W'($urandom_range(0, 31));
      cdb_valid   = ($urandom_range(0, 99) < 55);
      t = $urandom_range(0, DEPTH - 1);
      for (int k = 0; k < 4 && !(m_busy[t] && !m_done[t]); k++)
        t = $urandom_range(0, DEPTH - 1);
      cdb_tag  = TAG_W'(t);
      cdb_data = $urandom();
      lookup_tag_j = TAG_W'($urandom_range(0, DEPTH - 1));
      lookup_tag_k = TAG_W'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) lookup_tag_j = cdb_tag;
      if ($urandom_range(0, 3) == 0) lookup_tag_k = cdb_tag;
      flush = ($urandom_range(0, 99) < 2);
      if (c == 700) begin
        #3 rst_n = 1'b0;
      end
      if (c == 702) begin
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    idle_inputs();
    repeat (12) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
